// File: rtl/misalign_sequencer_pkg.sv
// Shared state encodings, access-size codes and the latched-request bundle
// for the misaligned-access sequencer. Option: MISALIGN_TRAP_EN (in top).
package misalign_sequencer_pkg;

   localparam logic [1:0] DM_NONE  = 2'b00;
   localparam logic [1:0] DM_BYTE  = 2'b01;
   localparam logic [1:0] DM_HWORD = 2'b10;
   localparam logic [1:0] DM_WORD  = 2'b11;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'b00,
      SEQ_SPLIT = 2'b01,
      SEQ_DONE  = 2'b10
   } seq_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        write;
      logic        ext;
   } seq_req_t;

   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] lsb
   );
      logic mis;
      case (size)
         DM_HWORD: mis = lsb[0];
         DM_WORD:  mis = |lsb;
         default:  mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Index of the final byte beat: N-1 for the latched size.
   function automatic logic [1:0] last_idx(input logic [1:0] size);
      return (size == DM_WORD) ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/seq_byte_merge.sv
// Merges the 4-byte capture buffer into one load result, applying
// halfword extension; store completions return zero.
module seq_byte_merge
   import misalign_sequencer_pkg::*;
(
   input  logic [31:0] bytes_i,
   input  logic [1:0]  size_i,
   input  logic        ext_i,
   input  logic        write_i,
   output logic [31:0] rdata_o
);

   logic sign;

   assign sign = ext_i & bytes_i[15];

   always_comb begin
      rdata_o = '0;
      if (!write_i) begin
         case (size_i)
            DM_HWORD: rdata_o = {{16{sign}}, bytes_i[15:0]};
            DM_WORD:  rdata_o = bytes_i;
            default:  rdata_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/misalign_sequencer.sv
// Memory-stage front end: aligned accesses pass through, misaligned ones are
// split into byte beats. MISALIGN_TRAP_EN replaces splitting with a trap.
module misalign_sequencer
   import misalign_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_write_status,
   input  logic [1:0]      req_read_status,
   input  logic            req_load_unsigned,
   output logic            stall,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [1:0]      mem_write_status,
   output logic [1:0]      mem_read_status,
   output logic            mem_load_unsigned,
`ifdef MISALIGN_TRAP_EN
   output logic            misalign_trap,
`endif
   input  logic [XLEN-1:0] mem_rdata
);

   seq_state_e      state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [XLEN-1:0] buf_q, buf_d;
   seq_req_t        lat_q, lat_d;

   logic            wr_req, rd_req, mis, last, resp_v;
   logic [1:0]      req_size;
   logic [7:0]      wbyte;
   logic [XLEN-1:0] merged;

   // A write wins over a simultaneous read.
   assign wr_req   = |req_write_status;
   assign rd_req   = |req_read_status;
   assign req_size = wr_req ? req_write_status : req_read_status;
   assign mis      = req_valid & is_misaligned(req_size, req_addr[1:0]);
   assign last     = (idx_q == last_idx(lat_q.size));
   assign wbyte    = lat_q.wdata[{idx_q, 3'b000} +: 8];

   seq_byte_merge u_merge (
      .bytes_i (buf_q),
      .size_i  (lat_q.size),
      .ext_i   (lat_q.ext),
      .write_i (lat_q.write),
      .rdata_o (merged)
   );

   always_comb begin
      state_d           = state_q;
      idx_d             = idx_q;
      buf_d             = buf_q;
      lat_d             = lat_q;
      mem_addr          = req_addr;
      mem_wdata         = req_wdata;
      mem_write_status  = req_write_status;
      mem_read_status   = req_read_status;
      mem_load_unsigned = req_load_unsigned;
      stall             = 1'b0;
      resp_v            = 1'b0;
      resp_rdata        = mem_rdata;
`ifdef MISALIGN_TRAP_EN
      misalign_trap     = 1'b0;
`endif
      unique case (state_q)
         SEQ_IDLE: begin
            if (mis) begin
               mem_write_status = DM_NONE;
               mem_read_status  = DM_NONE;
`ifdef MISALIGN_TRAP_EN
               misalign_trap    = 1'b1;
`else
               stall   = 1'b1;
               lat_d   = '{addr:  req_addr,
                           wdata: req_wdata,
                           size:  req_size,
                           write: wr_req,
                           ext:   req_load_unsigned};
               idx_d   = 2'd0;
               buf_d   = '0;
               state_d = SEQ_SPLIT;
`endif
            end else begin
               resp_v = req_valid & (wr_req | rd_req);
            end
         end
         SEQ_SPLIT: begin
            stall             = 1'b1;
            mem_addr          = lat_q.addr + XLEN'(idx_q);
            mem_wdata         = {{(XLEN-8){1'b0}}, wbyte};
            mem_write_status  = lat_q.write ? DM_BYTE : DM_NONE;
            mem_read_status   = lat_q.write ? DM_NONE : DM_BYTE;
            mem_load_unsigned = 1'b0;
            if (!lat_q.write) begin
               buf_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
            end
            idx_d = idx_q + 2'd1;
            if (last) begin
               state_d = SEQ_DONE;
            end
         end
         SEQ_DONE: begin
            mem_addr         = lat_q.addr;
            mem_wdata        = lat_q.wdata;
            mem_write_status = DM_NONE;
            mem_read_status  = DM_NONE;
            resp_v           = 1'b1;
            resp_rdata       = merged;
            state_d          = SEQ_IDLE;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   assign resp_valid = resp_v & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         lat_q   <= lat_d;
      end
   end

endmodule

// File: tb/tb_misalign_sequencer.sv
// Directed bench for misalign_sequencer with a behavioural aligner/memory.
// Build with MISALIGN_TRAP_EN to exercise the trap variant.
module tb_misalign_sequencer;

   localparam logic [31:0] BASE = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_write_status, req_read_status;
   logic        req_load_unsigned;
   logic        stall, resp_valid;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_write_status, mem_read_status;
   logic        mem_load_unsigned;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_trap;
`endif

   logic [7:0]  mem [0:15];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   misalign_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_write_status  (req_write_status),
      .req_read_status   (req_read_status),
      .req_load_unsigned (req_load_unsigned),
      .stall             (stall),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_write_status  (mem_write_status),
      .mem_read_status   (mem_read_status),
      .mem_load_unsigned (mem_load_unsigned),
`ifdef MISALIGN_TRAP_EN
      .misalign_trap     (misalign_trap),
`endif
      .mem_rdata         (mem_rdata)
   );

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off < 32'd16) ? mem[off[3:0]] : 8'h00;
   endfunction

   // Aligner model: load_unsigned=1 sign-extends.
   function automatic logic [31:0] model_read(
      input logic [31:0] a, input logic [1:0] st, input logic ext);
      logic [7:0] b0, b1, b2, b3;
      b0 = rd_byte(a);
      b1 = rd_byte(a + 32'd1);
      b2 = rd_byte(a + 32'd2);
      b3 = rd_byte(a + 32'd3);
      case (st)
         2'b01:   return {{24{ext & b0[7]}}, b0};
         2'b10:   return {{16{ext & b1[7]}}, b1, b0};
         2'b11:   return {b3, b2, b1, b0};
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      mem_rdata = '0;
      mem_rdata = model_read(mem_addr, mem_read_status, mem_load_unsigned);
   end

   always @(posedge clk) begin
      int n;
      logic [31:0] off;
      n = (mem_write_status == 2'b01) ? 1 :
          (mem_write_status == 2'b10) ? 2 :
          (mem_write_status == 2'b11) ? 4 : 0;
      for (int i = 0; i < n; i++) begin
         off = mem_addr + i - BASE;
         if (off < 32'd16) mem[off[3:0]] <= mem_wdata[8*i +: 8];
      end
   end

   task automatic set_req(input logic v, input logic [31:0] a,
      input logic [31:0] wd, input logic [1:0] ws, input logic [1:0] rs,
      input logic ext);
      req_valid         = v;
      req_addr          = a;
      req_wdata         = wd;
      req_write_status  = ws;
      req_read_status   = rs;
      req_load_unsigned = ext;
   endtask

   task automatic idle();
      set_req(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      #1;
      checks++; if (stall !== 1'b0) begin failures++;
         $display("FAIL rst_stall got=%h exp=0", stall); end
      checks++; if (resp_valid !== 1'b0) begin failures++;
         $display("FAIL rst_resp got=%h exp=0", resp_valid); end
      set_req(1'b1, BASE, 32'h0, 2'b00, 2'b11, 1'b0);
      #1;
      checks++; if (resp_valid !== 1'b0) begin failures++;
         $display("FAIL rst_resp_gated got=%h exp=0", resp_valid); end
      checks++; if (mem_read_status !== 2'b11) begin failures++;
         $display("FAIL rst_pass_rs got=%h exp=3", mem_read_status); end
      checks++; if (mem_addr !== BASE) begin failures++;
         $display("FAIL rst_pass_addr got=%h exp=%h", mem_addr, BASE); end
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_aligned_load(input logic [31:0] a,
      input logic [1:0] rs, input logic ext, input logic [31:0] exp);
      @(negedge clk);
      set_req(1'b1, a, 32'h0, 2'b00, rs, ext);
      #1;
      checks++; if (resp_valid !== 1'b1) begin failures++;
         $display("FAIL aln_resp a=%h got=%h exp=1", a, resp_valid); end
      checks++; if (resp_rdata !== exp) begin failures++;
         $display("FAIL aln_rdata a=%h got=%h exp=%h", a, resp_rdata, exp); end
      checks++; if (stall !== 1'b0) begin failures++;
         $display("FAIL aln_stall a=%h got=%h exp=0", a, stall); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_aligned_store();
      @(negedge clk);
      set_req(1'b1, BASE + 32'd8, 32'h1234_5678, 2'b11, 2'b00, 1'b0);
      #1;
      checks++; if (mem_write_status !== 2'b11) begin failures++;
         $display("FAIL alst_ws got=%h exp=3", mem_write_status); end
      checks++; if (resp_valid !== 1'b1 || stall !== 1'b0) begin failures++;
         $display("FAIL alst_hs got=%b%b exp=10", resp_valid, stall); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (resp_valid !== 1'b0) begin failures++;
         $display("FAIL alst_idle got=%h exp=0", resp_valid); end
      test_aligned_load(BASE + 32'd8, 2'b11, 1'b0, 32'h1234_5678);
   endtask

   task automatic test_misaligned_word();
      @(negedge clk);
      set_req(1'b1, BASE + 32'd1, 32'h0, 2'b00, 2'b11, 1'b0);
      #1;
      checks++; if (stall !== 1'b1 || resp_valid !== 1'b0) begin failures++;
         $display("FAIL mw_accept got=%b%b exp=10", stall, resp_valid); end
      checks++; if (mem_read_status !== 2'b00) begin failures++;
         $display("FAIL mw_accept_rs got=%h exp=0", mem_read_status); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 1) req_addr = 32'hDEAD_BEEF;
         #1;
         checks++; if (mem_addr !== BASE + 32'd1 + i) begin failures++;
            $display("FAIL mw_addr%0d got=%h exp=%h", i, mem_addr,
                     BASE + 32'd1 + i); end
         checks++; if (mem_read_status !== 2'b01 || mem_write_status !== 2'b00
                       || stall !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mw_beat%0d got=%h/%h/%b%b exp=1/0/10", i,
                     mem_read_status, mem_write_status, stall, resp_valid); end
      end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || stall !== 1'b0) begin failures++;
         $display("FAIL mw_done got=%b%b exp=10", resp_valid, stall); end
      checks++; if (resp_rdata !== 32'h9544_3322) begin failures++;
         $display("FAIL mw_rdata got=%h exp=95443322", resp_rdata); end
      checks++; if (mem_read_status !== 2'b00) begin failures++;
         $display("FAIL mw_done_rs got=%h exp=0", mem_read_status); end
      idle();
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b0) begin failures++;
         $display("FAIL mw_oneshot got=%h exp=0", resp_valid); end
   endtask

   task automatic test_misaligned_hword(input logic [31:0] a,
      input logic ext, input logic [31:0] exp, input logic b2b);
      @(negedge clk);
      set_req(1'b1, a, 32'h0, 2'b00, 2'b10, ext);
      #1;
      checks++; if (stall !== 1'b1) begin failures++;
         $display("FAIL mh_accept a=%h got=%h exp=1", a, stall); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++; if (mem_addr !== a + i || mem_load_unsigned !== 1'b0)
         begin
            failures++;
            $display("FAIL mh_beat%0d got=%h/%h exp=%h/0", i, mem_addr,
                     mem_load_unsigned, a + i); end
      end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp) begin
         failures++;
         $display("FAIL mh_done a=%h got=%b/%h exp=1/%h", a, resp_valid,
                  resp_rdata, exp); end
      if (b2b) begin
         set_req(1'b1, BASE + 32'd1, 32'h0, 2'b00, 2'b10, 1'b0);
         #1;
         checks++; if (mem_read_status !== 2'b00 || stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_hold got=%h/%h exp=0/0",
                     mem_read_status, stall); end
         @(negedge clk);
         #1;
         checks++; if (stall !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got=%b%b exp=10", stall, resp_valid); end
         repeat (2) @(negedge clk);
         @(negedge clk);
         #1;
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0422)
         begin
            failures++;
            $display("FAIL b2b_rdata got=%b/%h exp=1/00000422", resp_valid,
                     resp_rdata); end
      end
      idle();
   endtask

   task automatic test_misaligned_store();
      logic [31:0] wd;
      wd = 32'hAABB_CCDD;
      @(negedge clk);
      set_req(1'b1, BASE + 32'd2, wd, 2'b11, 2'b00, 1'b0);
      #1;
      checks++; if (mem_write_status !== 2'b00 || stall !== 1'b1) begin
         failures++;
         $display("FAIL ms_accept got=%h/%h exp=0/1", mem_write_status, stall);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++; if (mem_write_status !== 2'b01 || mem_read_status !== 2'b00
                       || mem_wdata[7:0] !== wd[8*i +: 8]
                       || mem_addr !== BASE + 32'd2 + i) begin
            failures++;
            $display("FAIL ms_beat%0d got=%h/%h/%h/%h exp=1/0/%h/%h", i,
                     mem_write_status, mem_read_status, mem_wdata[7:0],
                     mem_addr, wd[8*i +: 8], BASE + 32'd2 + i); end
      end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL ms_done got=%b/%h exp=1/0", resp_valid, resp_rdata);
      end
      idle();
      test_aligned_load(BASE, 2'b11, 1'b0, 32'hCCDD_2211);
      test_aligned_load(BASE + 32'd4, 2'b11, 1'b0, 32'h8877_AABB);
   endtask

   task automatic test_reset_mid_split();
      @(negedge clk);
      set_req(1'b1, BASE + 32'd2, 32'h0102_0304, 2'b11, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle();
      #1;
      checks++; if (stall !== 1'b0 || resp_valid !== 1'b0
                    || mem_write_status !== 2'b00) begin
         failures++;
         $display("FAIL rms_idle got=%b%b/%h exp=00/0", stall, resp_valid,
                  mem_write_status); end
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({mem[2], mem[3], mem[4], mem[5]} !== 32'h0403_BBAA) begin
         failures++;
         $display("FAIL rms_mem got=%h exp=0403bbaa",
                  {mem[2], mem[3], mem[4], mem[5]}); end
      test_aligned_load(BASE, 2'b11, 1'b0, 32'h0304_2211);
   endtask

`ifdef MISALIGN_TRAP_EN
   task automatic test_trap();
      @(negedge clk);
      set_req(1'b1, BASE + 32'd1, 32'h0, 2'b00, 2'b10, 1'b1);
      #1;
      checks++; if (misalign_trap !== 1'b1) begin failures++;
         $display("FAIL trap_raise got=%h exp=1", misalign_trap); end
      checks++; if (mem_read_status !== 2'b00 || mem_write_status !== 2'b00
                    || stall !== 1'b0 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL trap_quiet got=%h/%h/%b%b exp=0/0/00",
                  mem_read_status, mem_write_status, stall, resp_valid); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (misalign_trap !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL trap_clear got=%b%b exp=00", misalign_trap, stall); end
   endtask
`endif

   initial begin
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[4] = 8'h95; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
      for (int i = 8; i < 16; i++) mem[i] = 8'h00;
      test_reset();
      test_aligned_load(BASE, 2'b11, 1'b0, 32'h4433_2211);
`ifdef MISALIGN_TRAP_EN
      test_trap();
      test_aligned_load(BASE, 2'b11, 1'b0, 32'h4433_2211);
`else
      test_misaligned_word();
      test_misaligned_hword(BASE + 32'd3, 1'b1, 32'hFFFF_9544, 1'b0);
      test_misaligned_hword(BASE + 32'd3, 1'b0, 32'h0000_9544, 1'b0);
      test_misaligned_store();
      test_aligned_load(BASE + 32'd5, 2'b01, 1'b1, 32'hFFFF_FFAA);
      test_aligned_load(BASE + 32'd5, 2'b01, 1'b0, 32'h0000_00AA);
      test_aligned_load(BASE + 32'd6, 2'b10, 1'b1, 32'hFFFF_8877);
      test_reset_mid_split();
      test_misaligned_hword(BASE + 32'd3, 1'b0, 32'h0000_BB03, 1'b1);
`endif
      test_aligned_store();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
